// File: rtl/pdua.sv
`default_nettype none
// ------------------------------------------------------------------------
// pdua : datapath of the PDUA 8-bit teaching processor     Rev 1.0
// ------------------------------------------------------------------------
module pdua #(
   parameter int MAX_WIDTH  = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_rdn,
   input  logic                  enaf,
   input  logic [2:0]            selop,
   input  logic [1:0]            shamt,
   output logic                  C,
   output logic                  N,
   output logic                  P,
   output logic                  Z,
   input  logic                  bank_wr_en,
   input  logic [ADDR_WIDTH-1:0] BusB_addr,
   input  logic [ADDR_WIDTH-1:0] BusC_addr,
   input  logic                  sclr,
   input  logic                  ir_en,
   input  logic                  mar_en,
   input  logic                  mdr_en,
   input  logic                  mdr_alu_n,
   output logic [4:0]            out_IR
);

   localparam int c_NREG  = 2 ** ADDR_WIDTH;
   localparam int c_DEPTH = 2 ** MAX_WIDTH;

   logic [MAX_WIDTH-1:0] r_bank [c_NREG];
   logic [MAX_WIDTH-1:0] r_ram  [c_DEPTH];
   logic [MAX_WIDTH-1:0] r_mar;
   logic [MAX_WIDTH-1:0] r_mdr;
   // Only the opcode field of IR is ever observed, so only it is stored.
   logic [4:0]           r_ir;
   logic                 r_c;
   logic                 r_n;
   logic                 r_p;
   logic                 r_z;

   logic [MAX_WIDTH-1:0] w_busa;
   logic [MAX_WIDTH-1:0] w_busb;
   logic [MAX_WIDTH-1:0] w_busc;
   logic [MAX_WIDTH:0]   w_sum;
   logic [MAX_WIDTH-1:0] w_y;
   logic                 w_opcy;
   logic [MAX_WIDTH-1:0] w_r;
   logic                 w_cy;

   assign w_busa = r_bank[c_NREG-1];
   assign w_busb = r_bank[BusB_addr];
   assign w_busc = mdr_alu_n ? r_mdr : w_r;

   always_comb begin
      w_sum  = '0;
      w_y    = '0;
      w_opcy = 1'b0;
      case (selop)
         3'b000: w_y = w_busb;
         3'b001: begin
            w_sum  = {1'b0, w_busa} + {1'b0, w_busb};
            w_y    = w_sum[MAX_WIDTH-1:0];
            w_opcy = w_sum[MAX_WIDTH];
         end
         3'b010: begin
            w_sum  = {1'b0, w_busa} + {1'b0, ~w_busb} + (MAX_WIDTH+1)'(1);
            w_y    = w_sum[MAX_WIDTH-1:0];
            w_opcy = w_sum[MAX_WIDTH];
         end
         3'b011: w_y = w_busa & w_busb;
         3'b100: w_y = w_busa ^ w_busb;
         3'b101: w_y = ~w_busb;
         3'b110: begin
            w_sum  = {1'b0, w_busb} + (MAX_WIDTH+1)'(1);
            w_y    = w_sum[MAX_WIDTH-1:0];
            w_opcy = w_sum[MAX_WIDTH];
         end
         default: w_y = w_busa | w_busb;
      endcase
   end

   // Any active shift replaces the operation carry with the bit shifted out.
   always_comb begin
      w_r  = w_y;
      w_cy = w_opcy;
      case (shamt)
         2'b01: begin
            w_r  = {w_y[MAX_WIDTH-2:0], 1'b0};
            w_cy = w_y[MAX_WIDTH-1];
         end
         2'b10: begin
            w_r  = {1'b0, w_y[MAX_WIDTH-1:1]};
            w_cy = w_y[0];
         end
         2'b11: begin
            w_r  = {w_y[MAX_WIDTH-1], w_y[MAX_WIDTH-1:1]};
            w_cy = w_y[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < c_NREG; i++)
            r_bank[i] <= (i == 0) ? MAX_WIDTH'(1) : MAX_WIDTH'(i);
      end else if (bank_wr_en) begin
         r_bank[BusC_addr] <= w_busc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mar <= '0;
         r_mdr <= '0;
         r_ir  <= '0;
         r_c   <= 1'b0;
         r_n   <= 1'b0;
         r_p   <= 1'b0;
         r_z   <= 1'b0;
      end else if (sclr) begin
         r_mar <= '0;
         r_mdr <= '0;
         r_ir  <= '0;
         r_c   <= 1'b0;
         r_n   <= 1'b0;
         r_p   <= 1'b0;
         r_z   <= 1'b0;
      end else begin
         if (enaf) begin
            r_c <= w_cy;
            r_n <= w_r[MAX_WIDTH-1];
            r_z <= (w_r == '0);
            r_p <= ~^w_r;
         end
         if (mar_en)
            r_mar <= w_r;
         if (mdr_en)
            r_mdr <= wr_rdn ? w_r : r_ram[r_mar];
         if (ir_en)
            r_ir <= r_mdr[MAX_WIDTH-1:MAX_WIDTH-5];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_rdn)
         r_ram[r_mar] <= r_mdr;
   end

   assign C      = r_c;
   assign N      = r_n;
   assign P      = r_p;
   assign Z      = r_z;
   assign out_IR = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_pdua.sv
`default_nettype none
// tb_pdua : directed and random checks of the pdua datapath against a
// behavioural model of the register bank, RAM, MAR/MDR/IR and flags.
module tb_pdua;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_rdn = 1'b0, enaf = 1'b0, bank_wr_en = 1'b0, sclr = 1'b0;
   logic       ir_en = 1'b0, mar_en = 1'b0, mdr_en = 1'b0, mdr_alu_n = 1'b0;
   logic [2:0] selop = 3'd0;
   logic [1:0] shamt = 2'd0;
   logic [2:0] BusB_addr = 3'd0, BusC_addr = 3'd0;
   logic       C, N, P, Z;
   logic [4:0] out_IR;

   int checks   = 0;
   int failures = 0;

   logic [7:0] m_bank [8];
   logic [7:0] m_ram  [256];
   logic [7:0] m_mar, m_mdr, m_ir;
   logic       m_c, m_n, m_p, m_z;

   pdua dut (
      .clk(clk), .rst(rst), .wr_rdn(wr_rdn), .enaf(enaf), .selop(selop),
      .shamt(shamt), .C(C), .N(N), .P(P), .Z(Z), .bank_wr_en(bank_wr_en),
      .BusB_addr(BusB_addr), .BusC_addr(BusC_addr), .sclr(sclr),
      .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
      .mdr_alu_n(mdr_alu_n), .out_IR(out_IR)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

   // Returns {carry, result} from plain integer arithmetic.
   function automatic logic [8:0] ref_alu(input int op, input int sh,
                                          input int a, input int b);
      int y, cy, r;
      y = 0; cy = 0;
      case (op)
         0: y = b;
         1: begin y = (a + b) % 256;         cy = (a + b) / 256; end
         2: begin y = (a + 255 - b + 1) % 256; cy = (a + 255 - b + 1) / 256; end
         3: y = a & b;
         4: y = a ^ b;
         5: y = 255 - b;
         6: begin y = (b + 1) % 256;         cy = (b + 1) / 256; end
         default: y = a | b;
      endcase
      r = y;
      case (sh)
         1: begin cy = y / 128; r = (y * 2) % 256; end
         2: begin cy = y % 2;   r = y / 2; end
         3: begin cy = y % 2;   r = y / 2 + ((y >= 128) ? 128 : 0); end
         default: ;
      endcase
      return 9'(cy * 256 + r);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_bank[i] = (i == 0) ? 8'd1 : 8'(i);
      m_mar = 0; m_mdr = 0; m_ir = 0;
      m_c = 0; m_n = 0; m_p = 0; m_z = 0;
   endtask

   task automatic model_tick();
      logic [8:0] ar;
      logic [7:0] r, busc, old_mdr, old_mar, rd;
      ar      = ref_alu(int'(selop), int'(shamt), int'(m_bank[7]), int'(m_bank[BusB_addr]));
      r       = ar[7:0];
      busc    = mdr_alu_n ? m_mdr : r;
      old_mdr = m_mdr;
      old_mar = m_mar;
      rd      = m_ram[old_mar];
      if (bank_wr_en) m_bank[BusC_addr] = busc;
      if (wr_rdn) m_ram[old_mar] = old_mdr;
      if (sclr) begin
         m_mar = 0; m_mdr = 0; m_ir = 0;
         m_c = 0; m_n = 0; m_p = 0; m_z = 0;
      end else begin
         if (enaf) begin
            m_c = ar[8];
            m_n = (r >= 128);
            m_z = (r == 0);
            m_p = ($countones(r) % 2 == 0);
         end
         if (mar_en) m_mar = r;
         if (mdr_en) m_mdr = wr_rdn ? r : rd;
         if (ir_en)  m_ir  = old_mdr;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_C"}, {7'd0, C}, {7'd0, m_c});
      chk({tag, "_N"}, {7'd0, N}, {7'd0, m_n});
      chk({tag, "_P"}, {7'd0, P}, {7'd0, m_p});
      chk({tag, "_Z"}, {7'd0, Z}, {7'd0, m_z});
      chk({tag, "_outIR"}, {3'd0, out_IR}, {3'd0, m_ir[7:3]});
      chk({tag, "_MAR"}, dut.r_mar, m_mar);
      chk({tag, "_MDR"}, dut.r_mdr, m_mdr);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s_r%0d", tag, i), dut.r_bank[i], m_bank[i]);
      chk({tag, "_RAM[MAR]"}, dut.r_ram[m_mar], m_ram[m_mar]);
   endtask

   task automatic tick(input string tag);
      model_tick();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic set_in(input int sel, input int sh, input int bb, input int bc,
                         input bit bw, input bit ef, input bit ma, input bit md,
                         input bit wr, input bit ie, input bit mn, input bit sc);
      selop = 3'(sel); shamt = 2'(sh); BusB_addr = 3'(bb); BusC_addr = 3'(bc);
      bank_wr_en = bw; enaf = ef; mar_en = ma; mdr_en = md;
      wr_rdn = wr; ir_en = ie; mdr_alu_n = mn; sclr = sc;
   endtask

   // Asserts reset away from a clock edge, checks the asynchronous effect,
   // then releases it on a falling edge with all controls idle.
   task automatic apply_reset(input string tag);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst = 1'b1;
      tick({tag, "_idle"});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) m_ram[i] = 8'd0;
      model_reset();
      @(negedge clk);
      apply_reset("reset");

      // ACC <= ACC ^ A
      set_in(4, 0, 3, 7, 1, 1, 0, 0, 0, 0, 0, 0); tick("t1");
      chk("t1_acc_const", dut.r_bank[7], 8'h04);
      chk("t1_P_const", {7'd0, P}, 8'd0);

      apply_reset("reset2");
      set_in(0, 0, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0); tick("t2a");
      set_in(4, 0, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0); tick("t2b");
      chk("t2_acc_const", dut.r_bank[7], 8'h00);
      chk("t2_ZP_const", {6'd0, Z, P}, 8'd3);

      apply_reset("reset3");
      set_in(6, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0); tick("t3_inc");
      chk("t3_pc2_const", dut.r_bank[0], 8'h02);
      set_in(4, 0, 7, 7, 1, 0, 0, 0, 0, 0, 0, 0); tick("t3_clracc");
      set_in(5, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0); tick("t3_pcff");
      set_in(6, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0); tick("t3_wrap");
      chk("t3_pc0_const", dut.r_bank[0], 8'h00);
      chk("t3_C_const", {7'd0, C}, 8'd1);

      apply_reset("reset4");
      set_in(0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0); tick("t4_mar");
      set_in(0, 1, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0); tick("t4_mdr");
      set_in(0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick("t4_ram");
      chk("t4_ram6_const", dut.r_ram[6], 8'h06);

      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); tick("t5_rd");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick("t5_ir");
      set_in(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0); tick("t5_bank");
      chk("t5_r5_const", dut.r_bank[5], 8'h06);

      set_in(5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); tick("t6_flags");
      set_in(1, 0, 1, 0, 0, 1, 1, 1, 0, 1, 0, 1); tick("t6_sclr");
      chk("t6_mar_const", dut.r_mar, 8'h00);
      apply_reset("t6_midrst");

      for (int k = 0; k < 400; k++) begin
         set_in($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
         tick($sformatf("rnd%0d", k));
         if (k == 200) apply_reset("rnd_rst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
